// File: rtl/vec_pipe_pkg.sv
// Shared types for the vector forwarding/hazard slice.
// Tags hold in-flight writers; dest is stored zero-extended to MAX_AW.
package vec_pipe_pkg;

  localparam int MAX_AW = 8;

  typedef logic [MAX_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      we;
    reg_addr_t dest;
    logic      vf;
    logic      is_load;
  } tag_t;

  localparam reg_addr_t ZERO_REG = '0;

  function automatic logic operand_match(
    tag_t      t,
    logic      rd,
    reg_addr_t addr,
    logic      vf
  );
    return t.valid & t.we & rd
         & (addr != ZERO_REG)
         & (addr == t.dest)
         & (vf == t.vf);
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Priority match of one source operand against the tag pipeline.
// The youngest (lowest index) matching stage supplies the data.
module fwd_operand_sel
  import vec_pipe_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 1
) (
  input  tag_t [FWD_STAGES-1:0]        tags,
  input  logic                         rd,
  input  reg_addr_t                    addr,
  input  logic                         vf,
  input  logic [DATA_W-1:0]            rf,
  input  logic [FWD_STAGES*DATA_W-1:0] res,
  output logic [DATA_W-1:0]            out,
  output logic                         hit,
  output logic                         load_use
);

  // Walk oldest to youngest so the youngest match is the last write.
  always_comb begin
    out      = rf;
    hit      = 1'b0;
    load_use = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (operand_match(tags[k], rd, addr, vf)) begin
        out      = res[k*DATA_W +: DATA_W];
        hit      = 1'b1;
        load_use = tags[k].is_load && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/vec_forward_hazard_unit.sv
// Vector operand forwarding with load-use stall detection.
// Keeps a registered tag pipeline of writers from EX onward.
module vec_forward_hazard_unit
  import vec_pipe_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int REG_AW     = 4,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         stall_ext,
  input  logic                         of_valid,
  input  logic                         of_we,
  input  logic [REG_AW-1:0]            of_dest,
  input  logic                         of_vf,
  input  logic                         of_is_load,
  input  logic [NUM_SRC-1:0]           src_use,
  input  logic [NUM_SRC*REG_AW-1:0]    src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]    src_rf,
  input  logic [FWD_STAGES*DATA_W-1:0] stage_res,
  output logic [NUM_SRC*DATA_W-1:0]    src_out,
  output logic [NUM_SRC-1:0]           fwd_hit,
  output logic                         hazard_stall,
  output logic [CNT_W-1:0]             stall_count
);

  tag_t [FWD_STAGES-1:0] tags;
  tag_t                  push;
  logic [NUM_SRC-1:0]    load_use;

  assign push = '{
    valid:   of_valid,
    we:      of_we,
    dest:    reg_addr_t'(of_dest),
    vf:      of_vf,
    is_load: of_is_load
  };

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_operand_sel #(
      .DATA_W    (DATA_W),
      .FWD_STAGES(FWD_STAGES),
      .LOAD_LAT  (LOAD_LAT)
    ) u_sel (
      .tags    (tags),
      .rd      (src_use[g]),
      .addr    (reg_addr_t'(src_addr[g*REG_AW +: REG_AW])),
      .vf      (of_vf),
      .rf      (src_rf[g*DATA_W +: DATA_W]),
      .res     (stage_res),
      .out     (src_out[g*DATA_W +: DATA_W]),
      .hit     (fwd_hit[g]),
      .load_use(load_use[g])
    );
  end

  assign hazard_stall = of_valid & (|load_use);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags <= '0;
    end else if (flush) begin
      for (int k = 0; k < FWD_STAGES; k++) begin
        tags[k].valid <= 1'b0;
      end
    end else if (!stall_ext) begin
      for (int k = FWD_STAGES - 1; k > 0; k--) begin
        tags[k] <= tags[k-1];
      end
      tags[0] <= hazard_stall ? '0 : push;
    end
  end

  // Counter follows the stall even when a flush wins the tag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (hazard_stall && !stall_ext
                 && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: doc/vec_forward_hazard_unit.md
Name: vec_forward_hazard_unit

Overview:
- Parametrised successor to the vector operand-forwarding logic.
- Sits between operand fetch (OF) and the execute/memory/writeback pipeline.
- Keeps its own registered tag pipeline of in-flight writers (dest, VF, load flag) and forwards the youngest matching result to each of NUM_SRC source operands.
- Detects load-use hazards, raises a stall, inserts a bubble, and counts stall cycles.

Parameters:
- DATA_W, 128, operand/result width in bits
- REG_AW, 4, register address width; address 0 is never forwarded
- NUM_SRC, 2, number of source operands resolved per cycle
- FWD_STAGES, 3, pipeline stages after OF that can forward (index 0 = EX, youngest)
- LOAD_LAT, 1, first stage index at which load data is valid on stage_res (must be < FWD_STAGES)
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  invalidate all tag entries (branch/exception)
- stall_ext  in  1  external pipeline freeze (memory wait)
- of_valid  in  1  OF instruction is valid
- of_we  in  1  OF instruction writes a register
- of_dest  in  REG_AW  OF destination register
- of_vf  in  1  OF instruction register file select (1 = vector)
- of_is_load  in  1  OF instruction is a load
- src_use  in  NUM_SRC  per-operand "reads a register" (replaces ExtndSel decode)
- src_addr  in  NUM_SRC*REG_AW  source register addresses, operand i at [i*REG_AW +: REG_AW]
- src_rf  in  NUM_SRC*DATA_W  register-file read data
- stage_res  in  FWD_STAGES*DATA_W  result bus of each stage, stage k at [k*DATA_W +: DATA_W]
- src_out  out  NUM_SRC*DATA_W  resolved operand data
- fwd_hit  out  NUM_SRC  operand i was forwarded this cycle
- hazard_stall  out  1  hold OF/IF this cycle
- stall_count  out  CNT_W  saturating count of hazard_stall cycles

Behaviour:
- Tag entry k (k = 0..FWD_STAGES-1) holds {valid, we, dest, vf, is_load} of the instruction in stage k. All fields are registered.
- Operand i match at entry k:
  - valid_k & we_k & src_use[i] & (src_addr_i != 0)
  - & (src_addr_i == dest_k) & (of_vf == vf_k)
  - The VF comparison is identical for every operand and every stage.
- Forward selection: the lowest k that matches wins. src_out_i = stage_res[k]. fwd_hit[i] = 1. No match gives src_out_i = src_rf_i and fwd_hit[i] = 0.
- Load-use hazard: the winning match has is_load_k = 1 and k < LOAD_LAT. Then hazard_stall = of_valid. Data forwarded in that cycle is don't-care.
- src_out, fwd_hit and hazard_stall are combinational, computed from current inputs and registered tags. No added latency.
- Tag update on the rising clk edge, in priority order:
  1. flush: all valid = 0, regardless of stall_ext.
  2. stall_ext: all entries hold; no push; stall_count holds.
  3. hazard_stall: entries shift (k takes k-1); entry 0 takes a bubble (valid = 0); stall_count increments.
  4. Otherwise: entries shift; entry 0 takes {of_valid, of_we, of_dest, of_vf, of_is_load}.
- The oldest entry (FWD_STAGES-1) is dropped on each shift.
- stall_count saturates at all ones; it does not wrap.
- Reset (async, any time, including mid-stall):
  - All valid = 0 and stall_count = 0.
  - Hence hazard_stall = 0, fwd_hit = 0, src_out = src_rf immediately.
- flush and a pending hazard in the same cycle: the flush wins, and the count still increments when stall_ext = 0.
- Dest 0 writers are tracked but never match.

Decomposition:
- Shared package vec_pipe_pkg:
  - typedef tag_t struct {valid, we, dest, vf, is_load}
  - localparam ZERO_REG
  - helper function for the operand match predicate
- One sub-module, fwd_operand_sel: one-operand priority match and mux, instantiated NUM_SRC times via generate.
- The tag pipeline, hazard OR-reduction and counter stay in the top.

Test Plan:
- ALU back-to-back: push V3 (we, vf=1, non-load); next cycle OF reads V3 with vf=1 -> fwd_hit[0]=1, src_out_0 = stage_res[0] = 128'hA5A5…; with of_vf=0 instead -> fwd_hit=0, src_out = src_rf.
- Youngest priority: entries 0 and 2 both write R5 (stage_res[0]=1, stage_res[2]=2) -> src_out = 1; operand 1 on R5 in the same cycle -> also 1.
- Load-use: load to V4 at entry 0, OF reads V4 -> hazard_stall=1, entry 0 becomes bubble on the next edge, stall_count=1; next cycle hit at entry 1 forwards stage_res[1], hazard_stall=0.
- Register 0 and src_use=0: writer to R0 and an operand with src_use=0 matching a live dest -> no forward, src_out = src_rf.
- stall_ext during hazard: stall_ext=1 for 3 cycles with a pending load-use -> tags frozen, stall_count unchanged, hazard_stall stays 1.
- flush / reset: flush -> next cycle no hits. Counter preloaded to 16'hFFFE plus 3 stalls -> 16'hFFFF. Assert rst_n low mid-stall -> stall_count=0, hazard_stall=0 asynchronously.
